serial_tx_arbiter: RTL

//  Shares the single serial TX byte channel between NUM_REQ packet sources (register-map

---
 rtl/serial_tx_arbiter.sv | 120 ++++++++++++
 1 files changed

// File: rtl/serial_tx_arbiter.sv
// rtl/serial_tx_arbiter.sv - round-robin packet arbiter sharing one serial TX byte channel
// Grants are held per packet; a watchdog reclaims grants from owners that stop strobing.
module serial_tx_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int TIMEOUT = 4096,
  parameter int TO_W    = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [8*NUM_REQ-1:0] req_tx_data,
  input  logic [NUM_REQ-1:0]   req_new_tx_data,
  output logic [NUM_REQ-1:0]   req_tx_busy,
  output logic [NUM_REQ-1:0]   grant,
  output logic [7:0]           ser_tx_data,
  output logic                 ser_new_tx_data,
  input  logic                 ser_tx_busy,
  output logic                 timeout_evt,
  output logic [7:0]           drop_count
);

  localparam int IW = $clog2(NUM_REQ);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [NUM_REQ-1:0] ONE = NUM_REQ'(1);

  typedef enum logic [1:0] {IDLE, OWNED, RELEASE} state_t;

  state_t              state;
  logic [IW-1:0]       last;
  logic [IW-1:0]       pick;
  logic [IW-1:0]       idx;
  logic                pick_valid;
  logic [TO_W-1:0]     watchdog;
  logic [NUM_REQ-1:0]  dropped;
  logic                accept;
  logic                owner_req;
  logic [7:0]          owner_data;
  logic [3:0]          drop_num;
  logic [8:0]          drop_sum;

  // Busy covers the cycle after a forwarded byte, so strobes can never go out back to back.
  assign req_tx_busy = ~grant | {NUM_REQ{ser_tx_busy | ser_new_tx_data}};
  assign dropped     = req_new_tx_data & req_tx_busy;
  assign accept      = |(req_new_tx_data & ~req_tx_busy);

  always_comb begin
    owner_data = '0;
    owner_req  = 1'b0;
    drop_num   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        owner_data = req_tx_data[8*i +: 8];
        owner_req  = req[i];
      end
      if (dropped[i]) drop_num = drop_num + 4'd1;
    end
    drop_sum = {1'b0, drop_count} + {5'b0, drop_num};
  end

  // Scan from farthest to nearest so the entry just after last wins.
  always_comb begin
    pick_valid = 1'b0;
    pick       = '0;
    idx        = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx = IW'((int'(last) + k) % NUM_REQ);
      if (req[idx]) begin
        pick_valid = 1'b1;
        pick       = idx;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      grant           <= '0;
      last            <= IW'(NUM_REQ - 1);
      watchdog        <= '0;
      ser_tx_data     <= '0;
      ser_new_tx_data <= 1'b0;
      timeout_evt     <= 1'b0;
      drop_count      <= '0;
    end else begin
      ser_new_tx_data <= accept;
      if (accept) ser_tx_data <= owner_data;
      timeout_evt <= 1'b0;
      drop_count  <= drop_sum[8] ? 8'hff : drop_sum[7:0];
      case (state)
        IDLE, RELEASE: begin
          grant <= '0;
          state <= IDLE;
          if (pick_valid) begin
            grant    <= ONE << pick;
            last     <= pick;
            watchdog <= '0;
            state    <= OWNED;
          end
        end
        OWNED: begin
          if (accept) watchdog <= '0;
          else if (watchdog != '1) watchdog <= watchdog + 1'b1;
          if (!owner_req) begin
            grant <= '0;
            state <= RELEASE;
          end else if (TIMEOUT != 0 && !accept && watchdog == TO_LAST) begin
            grant       <= '0;
            timeout_evt <= 1'b1;
            state       <= RELEASE;
          end
        end
        default: begin
          grant <= '0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
